// File: rtl/clfsr_keystream_gen.sv
// Chaotic-LFSR keystream generator: Galois LFSR combined with a Q0.16 logistic-map
// register, emitting CHANNELS-word frames over a valid/ready handshake.
module clfsr_keystream_gen #(
  parameter int unsigned          WIDTH        = 8,
  parameter int unsigned          CHANNELS     = 3,
  parameter int unsigned          LFSR_LEN     = 32,
  parameter logic [LFSR_LEN-1:0]  TAPS         = LFSR_LEN'(32'h8020_0003),
  parameter logic [LFSR_LEN-1:0]  DEFAULT_SEED = LFSR_LEN'(32'hACE1_2468),
  parameter logic [15:0]          CHAOS_SEED   = 16'h8000,
  parameter int unsigned          WARMUP       = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         seed_load,
  input  logic [LFSR_LEN-1:0]          seed_lfsr,
  input  logic [15:0]                  seed_chaos,
  input  logic                         mode,
  // key_valid/key_ready: a frame transfers on any rising edge where both are high;
  // while key_valid is high, key_out is stable and key_valid only drops on a
  // transfer or a seed_load. key_ready is ignored while key_valid is low.
  output logic [CHANNELS*WIDTH-1:0]    key_out,
  output logic                         key_valid,
  input  logic                         key_ready,
  output logic [15:0]                  key_count
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned WU_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_FILL   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [LFSR_LEN-1:0]         lfsr_q, lfsr_raw, lfsr_step;
  logic [15:0]                 x_q, x_raw, x_step;
  logic [31:0]                 chaos_prod;
  logic [WIDTH-1:0]            word;
  logic                        mode_q;
  logic [IDX_W-1:0]            idx_q;
  logic [WU_W-1:0]             wu_cnt;
  logic [CHANNELS*WIDTH-1:0]   frame_buf, frame_next;

  logic step_en, fill_wr, publish, accept, fill_entry;

  // Core step datapath: next LFSR value, next chaos value and the keystream word.
  always_comb begin
    lfsr_raw  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    // Degenerate tap masks could collapse the register to zero; reload instead.
    lfsr_step = (lfsr_raw == '0) ? DEFAULT_SEED : lfsr_raw;

    chaos_prod = {16'h0000, x_q} * {16'h0000, ~x_q};
    x_raw      = 16'(chaos_prod >> 14);
    x_step     = x_raw;
    if (x_raw[15:4] == 12'h000) begin
      x_step = 16'h9E37 ^ {8'h00, lfsr_step[7:0]};
    end

    word = lfsr_step[WIDTH-1:0];
    if (mode_q) begin
      word = word ^ x_step[15 -: WIDTH];
    end

    frame_next = frame_buf;
    frame_next[idx_q*WIDTH +: WIDTH] = word;
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    step_en = 1'b0;
    fill_wr = 1'b0;
    publish = 1'b0;
    accept  = 1'b0;
    if (seed_load) begin
      state_d = (WARMUP == 0) ? ST_FILL : ST_WARMUP;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          if (WARMUP == 0) begin
            state_d = ST_FILL;
          end else begin
            step_en = 1'b1;
            if (wu_cnt == WU_LAST) state_d = ST_FILL;
          end
        end
        ST_FILL: begin
          step_en = 1'b1;
          fill_wr = 1'b1;
          if (idx_q == IDX_LAST) begin
            publish = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (key_valid && key_ready) begin
            accept  = 1'b1;
            state_d = ST_FILL;
          end
        end
        default: state_d = ST_WARMUP;
      endcase
    end
    fill_entry = (state_d == ST_FILL) && ((state_q != ST_FILL) || seed_load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q    <= DEFAULT_SEED;
      x_q       <= CHAOS_SEED;
      key_out   <= '0;
      key_valid <= 1'b0;
      key_count <= 16'h0000;
      idx_q     <= '0;
      wu_cnt    <= '0;
      mode_q    <= 1'b0;
      frame_buf <= '0;
    end else begin
      if (fill_entry) mode_q <= mode;
      if (seed_load) begin
        lfsr_q    <= (seed_lfsr == '0) ? DEFAULT_SEED : seed_lfsr;
        x_q       <= (seed_chaos == 16'h0000) ? CHAOS_SEED : seed_chaos;
        key_valid <= 1'b0;
        idx_q     <= '0;
        wu_cnt    <= '0;
      end else begin
        if (step_en) begin
          lfsr_q <= lfsr_step;
          x_q    <= x_step;
        end
        if (step_en && (state_q == ST_WARMUP)) begin
          wu_cnt <= (state_d == ST_FILL) ? '0 : wu_cnt + 1'b1;
        end
        if (fill_wr) begin
          frame_buf <= frame_next;
          idx_q     <= publish ? '0 : idx_q + 1'b1;
        end
        if (publish) begin
          key_out   <= frame_next;
          key_valid <= 1'b1;
        end
        if (accept) begin
          key_valid <= 1'b0;
          key_count <= key_count + 16'd1;
          idx_q     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clfsr_keystream_gen.sv
// Directed bench for clfsr_keystream_gen with an 8-bit LFSR (taps B8), no warm-up.
module tb_clfsr_keystream_gen;

  logic        clk;
  logic        rst;
  logic        seed_load;
  logic [7:0]  seed_lfsr;
  logic [15:0] seed_chaos;
  logic        mode;
  logic [23:0] key_out;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key_count;

  int n_cmp;
  int n_bad;
  int n_edges;

  clfsr_keystream_gen #(
    .WIDTH        (8),
    .CHANNELS     (3),
    .LFSR_LEN     (8),
    .TAPS         (8'hB8),
    .DEFAULT_SEED (8'h01),
    .CHAOS_SEED   (16'h8000),
    .WARMUP       (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_lfsr  (seed_lfsr),
    .seed_chaos (seed_chaos),
    .mode       (mode),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_count  (key_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_edges, output int n);
    n = 0;
    while (!key_valid && n < max_edges) begin
      step();
      n++;
    end
    check_eq("valid_seen", 32'(key_valid), 32'd1);
  endtask

  task automatic reseed(input logic [7:0] sl, input logic [15:0] sc, input logic m);
    seed_load  = 1'b1;
    seed_lfsr  = sl;
    seed_chaos = sc;
    mode       = m;
    step();
    seed_load  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; seed_load = 1'b0; seed_lfsr = '0; seed_chaos = '0;
    mode = 1'b0; key_ready = 1'b0;
    #12;
    check_eq("rst_key_out", 32'(key_out), 32'h0);
    check_eq("rst_key_valid", 32'(key_valid), 32'h0);
    check_eq("rst_key_count", 32'(key_count), 32'h0);
    rst = 1'b0;

    // default seeds after reset, plain mode
    wait_valid(10, n_edges);
    check_eq("post_rst_frame", 32'(key_out), 32'h2E5CB8);

    // plain LFSR from seed 01, latency of CHANNELS edges
    reseed(8'h01, 16'h8000, 1'b0);
    check_eq("reseed_drops_valid", 32'(key_valid), 32'h0);
    wait_valid(10, n_edges);
    check_eq("plain_latency", 32'(n_edges), 32'd3);
    check_eq("plain_frame", 32'(key_out), 32'h2E5CB8);
    check_eq("plain_count", 32'(key_count), 32'h0);

    // backpressure: frame held, core frozen
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_valid", 32'(key_valid), 32'd1);
      check_eq("hold_key_out", 32'(key_out), 32'h2E5CB8);
    end
    key_ready = 1'b1;
    step();
    check_eq("accept_count", 32'(key_count), 32'd1);
    check_eq("accept_valid", 32'(key_valid), 32'd0);
    wait_valid(10, n_edges);
    check_eq("frame2", 32'(key_out), 32'hE1B317);
    step();
    wait_valid(10, n_edges);
    check_eq("throughput_edges", 32'(n_edges), 32'd3);
    check_eq("frame3", 32'(key_out), 32'h3264C8);
    key_ready = 1'b0;
    check_eq("count_two", 32'(key_count), 32'd2);

    // chaotic mode: x steps FFFE, 9E6B (guard), F188
    reseed(8'h01, 16'h8000, 1'b1);
    check_eq("pending_not_counted", 32'(key_count), 32'd2);
    wait_valid(10, n_edges);
    check_eq("chaos_frame", 32'(key_out), 32'hDFC247);

    // zero seeds fall back to defaults
    reseed(8'h00, 16'h0000, 1'b1);
    wait_valid(10, n_edges);
    check_eq("zero_seed_chaos_frame", 32'(key_out), 32'hDFC247);
    reseed(8'h00, 16'h0000, 1'b0);
    wait_valid(10, n_edges);
    check_eq("zero_seed_plain_frame", 32'(key_out), 32'h2E5CB8);

    // reseed in HOLD racing a handshake, then again mid-FILL
    key_ready = 1'b1;
    reseed(8'h17, 16'h1234, 1'b0);
    check_eq("hold_reseed_valid", 32'(key_valid), 32'd0);
    check_eq("hold_reseed_count", 32'(key_count), 32'd2);
    step();
    reseed(8'h17, 16'h1234, 1'b0);
    wait_valid(10, n_edges);
    check_eq("fill_reseed_latency", 32'(n_edges), 32'd3);
    check_eq("fill_reseed_frame", 32'(key_out), 32'hC8E1B3);
    check_eq("fill_reseed_count", 32'(key_count), 32'd2);
    step();
    check_eq("count_three", 32'(key_count), 32'd3);

    // asynchronous reset in the middle of a fill
    step();
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_key_out", 32'(key_out), 32'h0);
    check_eq("async_rst_valid", 32'(key_valid), 32'h0);
    check_eq("async_rst_count", 32'(key_count), 32'h0);
    key_ready = 1'b0;
    #3;
    rst = 1'b0;
    wait_valid(10, n_edges);
    check_eq("post_async_rst_frame", 32'(key_out), 32'h2E5CB8);

    // counter wrap from FFFF
    force dut.key_count = 16'hFFFF;
    #1;
    release dut.key_count;
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check_eq("count_wrap", 32'(key_count), 32'h0);
    check_eq("wrap_valid", 32'(key_valid), 32'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
